wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master, one-slave Wishbone classic arbiter that shares the system bus between the CPU (master 0) and a second bus master such as a debug/DMA port (master 1). Grants are held for a whole `cyc` cycle. Ownership rotates round-robin when both masters request. The block sits between the masters and the slave-side address decoder; it only sequences ownership and multiplexes signals.

## Interface
- `TIMEOUT_CYCLES`, default 255: stall limit for the bus watchdog, in clock cycles; range 1..65535 (used only with `WB_ARBITER_TIMEOUT_EN`).
- `clk_i  input  1  system clock; all state updates on rising edge`
- `rst_ni  input  1  reset; synchronous and active-low`
- `m0_cyc_i, m1_cyc_i  input  1  per-master bus cycle request`
- `m0_stb_i, m1_stb_i  input  1  per-master strobe`
- `m0_we_i, m1_we_i  input  1  per-master write enable`
- `m0_adr_i, m1_adr_i  input  32  per-master address`
- `m0_dat_i, m1_dat_i  input  32  per-master write data`
- `m0_sel_i, m1_sel_i  input  4  per-master byte selects`
- `m0_dat_o, m1_dat_o  output  32  read data; both driven directly from s_dat_i`
- `m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_rty_o, m1_rty_o  output  1  per-master termination signals, gated by grant`
- `s_cyc_o, s_stb_o, s_we_o  output  1  slave-side cycle, strobe, write enable`
- `s_adr_o  output  32  slave-side address`
- `s_dat_o  output  32  slave-side write data`
- `s_sel_o  output  4  slave-side byte selects`
- `s_dat_i  input  32  slave read data`
- `s_ack_i, s_err_i, s_rty_i  input  1  slave terminations`
- `grant_o  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle`

## Operation
- States: IDLE, GRANT0, GRANT1. `grant_o` is decoded from the state. The `last` register (1 bit) records the most recent owner.
- IDLE:
  - Only m0_cyc_i high: go to GRANT0.
  - Only m1_cyc_i high: go to GRANT1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
- GRANTx: hold while mx_cyc_i is high. On mx_cyc_i low:
  - If the other master's cyc is high, go directly to the other GRANT.
  - Otherwise go to IDLE.
  - In both cases, `last` is set to x.
- While in GRANTx:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o equal master x's inputs, combinationally.
  - mx_ack_o, mx_err_o and mx_rty_o equal s_ack_i, s_err_i and s_rty_i.
  - The non-granted master's ack, err and rty are 0.
- IDLE drives:
  - s_cyc_o = s_stb_o = 0.
  - s_we_o = 0, s_adr_o = 0, s_dat_o = 0, s_sel_o = 0.
  - All terminations = 0.
- The arbiter never preempts an owner holding cyc. Starvation-freedom relies on masters dropping cyc between transactions.

## Timing
- Reset (rst_ni low at an edge):
  - state = IDLE, `last` = 1, so m0 wins the first contention.
  - All outputs take their IDLE values.
  - Reset mid-transaction aborts the grant; no termination is issued to the master.
- Grant latency: one cycle. A cyc request sampled at edge N is visible at the slave from edge N onward (the state is registered at N).
- Handoff: zero idle cycles when the other master is waiting. The new owner's signals reach the slave in the cycle after the old owner's cyc low is sampled.
- Terminations pass through combinationally, with zero added latency.
- Simultaneous requests in IDLE are resolved by `last` only. A request arriving in the same cycle as the owner releases does not change the round-robin order.

## Configuration
- Macro `WB_ARBITER_TIMEOUT_EN`, when defined:
  - A 16-bit counter clears on grant change, IDLE, or any s_ack_i/s_err_i/s_rty_i.
  - It increments each cycle in GRANTx with s_stb_o high.
  - When the count reaches TIMEOUT_CYCLES, for exactly one cycle:
    - mx_err_o = 1.
    - s_cyc_o = s_stb_o = 0.
    - The counter clears.
  - The master must then terminate its cycle.
- Macro not defined: no counter; a stalled slave holds the grant indefinitely.

## Test plan
- Reset, then only m0 writes 0xDEADBEEF to 0x100 with sel 1111:
  - grant_o = 01 one edge after m0_cyc_i.
  - s_adr_o = 0x100, s_dat_o = 0xDEADBEEF.
  - s_ack_i routes to m0_ack_o; m1_ack_o stays 0.
- m0 and m1 raise cyc in the same cycle right after reset:
  - m0 granted first.
  - After m0 drops cyc, grant_o becomes 10 on the next edge, with no IDLE cycle.
- Both masters request continuously, each dropping cyc after a one-beat transaction, for 8 transactions: grants alternate 01, 10, 01, …
- m1 owns the bus and m0 requests mid-transaction: m1 keeps the grant until m1_cyc_i falls; m0 sees ack = 0 throughout.
- rst_ni pulled low during a GRANT1 transaction: grant_o = 00 and s_cyc_o = 0 on the next edge; m1 receives no ack or err.
- With `WB_ARBITER_TIMEOUT_EN` and TIMEOUT_CYCLES = 4, slave never acks: m0_err_o pulses high for one cycle after 4 stalled strobe cycles; s_stb_o is 0 in that cycle.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle for the two-master / one-slave Wishbone arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_arbiter_if;
    logic        m0_cyc_i, m1_cyc_i;
    logic        m0_stb_i, m1_stb_i;
    logic        m0_we_i,  m1_we_i;
    logic [31:0] m0_adr_i, m1_adr_i;
    logic [31:0] m0_dat_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o;
    logic        m0_err_o, m1_err_o;
    logic        m0_rty_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  grant_o;

    modport slave (
        input  m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
        input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        output m0_rty_o, m1_rty_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output s_sel_o, grant_o
    );

    modport master (
        output m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
        output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        input  m0_rty_o, m1_rty_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  s_sel_o, grant_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter; grant held for a whole cyc.
// Optional stall watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic         clk_i,
    input logic         rst_ni,
    wb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT_CYCLES out of range 1..65535");
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                // Contention goes to whichever master did not own the bus last.
                if (bus.m0_cyc_i && bus.m1_cyc_i) state_d = last_q ? GRANT0 : GRANT1;
                else if (bus.m0_cyc_i)            state_d = GRANT0;
                else if (bus.m1_cyc_i)            state_d = GRANT1;
            end
            GRANT0: begin
                if (!bus.m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = bus.m1_cyc_i ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!bus.m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = bus.m0_cyc_i ? GRANT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic        stb_granted;

    always_comb begin
        timeout     = (state_q != IDLE) && (cnt_q == TO_LIMIT);
        stb_granted = (state_q == GRANT0 && bus.m0_stb_i) ||
                      (state_q == GRANT1 && bus.m1_stb_i);
        cnt_d       = cnt_q;
        if (state_q == IDLE || state_d != state_q || timeout ||
            bus.s_ack_i || bus.s_err_i || bus.s_rty_i)
            cnt_d = '0;
        else if (stb_granted)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Slave-side mux and termination routing, decoded from the registered owner.
    always_comb begin
        bus.grant_o  = 2'b00;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_adr_o  = '0;
        bus.s_dat_o  = '0;
        bus.s_sel_o  = '0;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m0_rty_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        bus.m1_rty_o = 1'b0;
        bus.m0_dat_o = bus.s_dat_i;
        bus.m1_dat_o = bus.s_dat_i;
        unique case (state_q)
            GRANT0: begin
                bus.grant_o  = 2'b01;
                bus.s_cyc_o  = bus.m0_cyc_i & ~timeout;
                bus.s_stb_o  = bus.m0_stb_i & ~timeout;
                bus.s_we_o   = bus.m0_we_i;
                bus.s_adr_o  = bus.m0_adr_i;
                bus.s_dat_o  = bus.m0_dat_i;
                bus.s_sel_o  = bus.m0_sel_i;
                bus.m0_ack_o = bus.s_ack_i;
                bus.m0_err_o = bus.s_err_i | timeout;
                bus.m0_rty_o = bus.s_rty_i;
            end
            GRANT1: begin
                bus.grant_o  = 2'b10;
                bus.s_cyc_o  = bus.m1_cyc_i & ~timeout;
                bus.s_stb_o  = bus.m1_stb_i & ~timeout;
                bus.s_we_o   = bus.m1_we_i;
                bus.s_adr_o  = bus.m1_adr_i;
                bus.s_dat_o  = bus.m1_dat_i;
                bus.s_sel_o  = bus.m1_sel_i;
                bus.m1_ack_o = bus.s_ack_i;
                bus.m1_err_o = bus.s_err_i | timeout;
                bus.m1_rty_o = bus.s_rty_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter with an expected-output queue and negedge monitor.
module tb_wb_arbiter;
  localparam int W = 143;

  logic clk;
  logic rst_n;
  wb_arbiter_if bus();

  wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_bad = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic set_m(input int m, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      bus.m0_cyc_i = cyc; bus.m0_stb_i = cyc; bus.m0_we_i = we;
      bus.m0_adr_i = adr; bus.m0_dat_i = dat; bus.m0_sel_i = sel;
    end else begin
      bus.m1_cyc_i = cyc; bus.m1_stb_i = cyc; bus.m1_we_i = we;
      bus.m1_adr_i = adr; bus.m1_dat_i = dat; bus.m1_sel_i = sel;
    end
  endtask

  task automatic set_s(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
    bus.s_ack_i = ack; bus.s_err_i = err; bus.s_rty_i = rty; bus.s_dat_i = dat;
  endtask

  // Expected outputs for this cycle given the hand-specified owner g and watchdog pulse to.
  function automatic logic [W-1:0] exp_vec(input logic [1:0] g, input logic to);
    logic cyc, stb, we, a0, a1, e0, e1, r0, r1;
    logic [31:0] adr, dat;
    logic [3:0] sel;
    {cyc, stb, we, a0, a1, e0, e1, r0, r1} = '0;
    adr = '0; dat = '0; sel = '0;
    if (g == 2'b01) begin
      cyc = bus.m0_cyc_i & ~to; stb = bus.m0_stb_i & ~to; we = bus.m0_we_i;
      adr = bus.m0_adr_i; dat = bus.m0_dat_i; sel = bus.m0_sel_i;
      a0 = bus.s_ack_i; e0 = bus.s_err_i | to; r0 = bus.s_rty_i;
    end else if (g == 2'b10) begin
      cyc = bus.m1_cyc_i & ~to; stb = bus.m1_stb_i & ~to; we = bus.m1_we_i;
      adr = bus.m1_adr_i; dat = bus.m1_dat_i; sel = bus.m1_sel_i;
      a1 = bus.s_ack_i; e1 = bus.s_err_i | to; r1 = bus.s_rty_i;
    end
    return {g, cyc, stb, we, adr, dat, sel, a0, a1, e0, e1, r0, r1, bus.s_dat_i, bus.s_dat_i};
  endfunction

  task automatic vec(input string name, input logic [1:0] g, input logic to);
    exp_q.push_back(exp_vec(g, to));
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    string nm;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.grant_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o,
             bus.s_sel_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o,
             bus.m0_rty_o, bus.m1_rty_o, bus.m0_dat_o, bus.m1_dat_o};
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    @(posedge clk);
    #1;
    vec("reset", 2'b00, 0);
    rst_n = 1'b1;

    // single master write
    set_m(0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    vec("t1_req", 2'b00, 0);
    set_s(1, 0, 0, 32'h1234_5678);
    vec("t1_ack", 2'b01, 0);
    set_m(0, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, 32'h1234_5678);
    vec("t1_drop", 2'b01, 0);
    vec("t1_idle", 2'b00, 0);

    // simultaneous request right after reset: m0 first, then zero-gap handoff
    rst_n = 1'b0;
    vec("t2_rst", 2'b00, 0);
    rst_n = 1'b1;
    set_m(0, 1, 0, 32'h0000_0200, 32'h0, 4'h3);
    set_m(1, 1, 1, 32'h0000_0300, 32'hCAFE_0001, 4'hC);
    vec("t2_both", 2'b00, 0);
    set_s(1, 0, 0, 32'hA5A5_0000);
    vec("t2_g0", 2'b01, 0);
    set_m(0, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, 32'hA5A5_0000);
    vec("t2_m0drop", 2'b01, 0);
    set_s(1, 0, 0, 32'hA5A5_0001);
    vec("t2_g1", 2'b10, 0);
    set_m(1, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    vec("t2_m1drop", 2'b10, 0);
    vec("t2_idle", 2'b00, 0);

    // continuous contention, eight one-beat transactions
    for (int i = 0; i < 8; i++) begin
      set_m(0, 1, 1, 32'h1000 + i, 32'h100 + i, 4'hF);
      set_m(1, 1, 0, 32'h2000 + i, 32'h200 + i, 4'h5);
      if (i == 0) vec("t3_both", 2'b00, 0);
      set_s(1, 0, 0, 32'h0 + i);
      vec($sformatf("t3_ack%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 0);
      set_m(i % 2, 0, 0, '0, '0, '0);
      set_s(0, 0, 0, '0);
      vec($sformatf("t3_drop%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 0);
    end
    set_m(0, 0, 0, '0, '0, '0);
    vec("t3_tail", 2'b01, 0);
    vec("t3_idle", 2'b00, 0);

    // contention with last = m0 must favour m1
    set_m(0, 1, 0, 32'h3000, 32'h0, 4'h1);
    set_m(1, 1, 1, 32'h4000, 32'h77, 4'h2);
    vec("rr_both", 2'b00, 0);
    vec("rr_g1", 2'b10, 0);
    set_m(1, 0, 0, '0, '0, '0);
    vec("rr_m1drop", 2'b10, 0);
    vec("rr_g0", 2'b01, 0);
    set_m(0, 0, 0, '0, '0, '0);
    vec("rr_m0drop", 2'b01, 0);
    vec("rr_idle", 2'b00, 0);

    // no preemption: m0 requests while m1 owns
    set_m(1, 1, 1, 32'h0000_0400, 32'h55AA_55AA, 4'h1);
    vec("t4_req", 2'b00, 0);
    vec("t4_g1", 2'b10, 0);
    set_m(0, 1, 0, 32'h0000_0500, 32'h0, 4'hF);
    set_s(0, 0, 1, 32'hBEEF_0000);
    vec("t4_rty", 2'b10, 0);
    set_s(1, 0, 0, 32'hBEEF_0001);
    vec("t4_ack", 2'b10, 0);
    set_m(1, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    vec("t4_m1drop", 2'b10, 0);
    set_s(0, 1, 0, 32'h0BAD_0BAD);
    vec("t4_g0_err", 2'b01, 0);
    set_m(0, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    vec("t4_m0drop", 2'b01, 0);
    vec("t4_idle", 2'b00, 0);

    // reset during a GRANT1 transaction
    set_m(1, 1, 0, 32'h0000_0600, 32'h0, 4'hF);
    vec("t5_req", 2'b00, 0);
    vec("t5_g1", 2'b10, 0);
    rst_n = 1'b0;
    vec("t5_rst_low", 2'b10, 0);
    set_s(1, 1, 0, 32'h6666_6666);
    vec("t5_rst_idle", 2'b00, 0);
    rst_n = 1'b1;
    set_m(1, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    vec("t5_idle", 2'b00, 0);

`ifdef WB_ARBITER_TIMEOUT_EN
    // stalled slave: err pulse after four strobe cycles
    set_m(0, 1, 1, 32'h0000_0700, 32'h1, 4'hF);
    vec("to_req", 2'b00, 0);
    for (int i = 0; i < 4; i++) vec($sformatf("to_stall%0d", i), 2'b01, 0);
    vec("to_err", 2'b01, 1);
    set_m(0, 0, 0, '0, '0, '0);
    vec("to_drop", 2'b01, 0);
    vec("to_idle", 2'b00, 0);
`endif

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
